// File: rtl/riscv_pkg.sv
// Shared pipeline definitions for riscv_core: datapath width, the canonical
// NOP, the default reset vector and the IF/ID pipeline-register layout that
// decode and the hazard unit also consume.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- the bubble placed in IF/ID on a flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

  // Force a byte address onto a word boundary by clearing bits [1:0]
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and IMEM (slave).
// The read is purely combinational: imem_rdata answers imem_addr in the same
// cycle, so there is no handshake.
interface if_stage_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush, hold and load controls.
// Priority: rst > flush > hold > load. A flush turns the entry into a bubble
// (NOP, valid=0) but keeps pc/pc4 so decode never sees a stale-looking PC jump.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   hold,
  input  if_id_t load_data,
  output if_id_t q
);

  if_id_t q_reg;
  if_id_t q_next;

  // Select the next register contents from the flush/hold/load controls
  always_comb begin
    q_next = q_reg;
    if (flush) begin
      q_next.instr = NOP_INSTR;
      q_next.valid = 1'b0;
    end else if (!hold) begin
      q_next = load_data;
    end
  end

  // Register update; reset yields an empty bubble with zeroed PCs
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg.pc    <= '0;
      q_reg.pc4   <= '0;
      q_reg.instr <= NOP_INSTR;
      q_reg.valid <= 1'b0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the IMEM address, and fills
// the IF/ID register. Per-cycle priority is rst > redirect > stall > fetch.
// Also keeps a sticky misaligned-target flag and fetch/flush counters.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = riscv_pkg::XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  if_stage_if.master       imem,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [XLEN-1:0]  if_id_pc4,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic             misalign_err,
  output logic [31:0]      fetch_count,
  output logic [31:0]      flush_count
);

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic            misalign_reg;
  logic            misalign_next;
  logic [31:0]     fetch_count_reg;
  logic [31:0]     fetch_count_next;
  logic [31:0]     flush_count_reg;
  logic [31:0]     flush_count_next;

  if_id_t if_id_load;
  if_id_t if_id_q;

  // Sequential successor; wraps naturally at 2^XLEN
  assign pc_plus4 = pc_reg + XLEN'(4);

  // IMEM sees the current PC at all times, reset included
  assign imem.imem_addr = pc_reg;

  // Next PC, counters and sticky flag following the per-cycle priority
  always_comb begin
    pc_next          = pc_reg;
    misalign_next    = misalign_reg;
    fetch_count_next = fetch_count_reg;
    flush_count_next = flush_count_reg;
    if (redirect) begin
      pc_next          = align_word(redirect_pc);
      flush_count_next = flush_count_reg + 32'd1;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_next = 1'b1;
      end
    end else if (!stall) begin
      pc_next          = pc_plus4;
      fetch_count_next = fetch_count_reg + 32'd1;
    end
  end

  // PC, flag and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      misalign_reg    <= 1'b0;
      fetch_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      pc_reg          <= pc_next;
      misalign_reg    <= misalign_next;
      fetch_count_reg <= fetch_count_next;
      flush_count_reg <= flush_count_next;
    end
  end

  // Entry presented to IF/ID when neither flushing nor holding
  always_comb begin
    if_id_load.pc    = pc_reg;
    if_id_load.pc4   = pc_plus4;
    if_id_load.instr = imem.imem_rdata;
    if_id_load.valid = 1'b1;
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .hold      (stall),
    .load_data (if_id_load),
    .q         (if_id_q)
  );

  assign if_id_pc     = if_id_q.pc;
  assign if_id_pc4    = if_id_q.pc4;
  assign if_id_instr  = if_id_q.instr;
  assign if_id_valid  = if_id_q.valid;
  assign misalign_err = misalign_reg;
  assign fetch_count  = fetch_count_reg;
  assign flush_count  = flush_count_reg;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage riscv_core pipeline. It holds the PC, drives the instruction-memory address and captures the fetched word into the IF/ID pipeline register that feeds decode. It honours stall requests from the hazard unit and redirect/flush requests from EX (branch taken = id_ex_Branch & zero). It also keeps a sticky misalignment flag and fetch/flush performance counters for bench visibility.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
XLEN, 32, datapath and PC width.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID this cycle
redirect  in  1  EX branch taken: flush IF/ID and load target
redirect_pc  in  XLEN  branch/jump target from EX
imem_addr  out  XLEN  byte address to IMEM; combinational = pc
imem_rdata  in  32  instruction word; combinational read of imem_addr, same cycle
if_id_pc  out  XLEN  PC of instruction held in IF/ID
if_id_pc4  out  XLEN  if_id_pc + 4
if_id_instr  out  32  instruction held in IF/ID
if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0
fetch_count  out  32  instructions that entered IF/ID valid
flush_count  out  32  number of redirects accepted

Behaviour:
- Reset, rst=1 at a clock edge: pc=RESET_PC; if_id_pc=0; if_id_pc4=0; if_id_instr=NOP (32'h0000_0013); if_id_valid=0; misalign_err=0; both counters=0. rst overrides every other input, including mid-redirect or mid-stall.
- imem_addr = pc at all times, including during reset.
- Per-cycle priority: rst > redirect > stall > normal fetch.
- Normal (redirect=0, stall=0):
  - pc <= pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - if_id_pc <= pc; if_id_pc4 <= pc+4; if_id_instr <= imem_rdata; if_id_valid <= 1.
  - fetch_count += 1.
- Stall (redirect=0, stall=1):
  - pc and all IF/ID outputs hold.
  - Counters hold.
  - imem_rdata is ignored.
- Redirect (redirect=1, stall ignored):
  - pc <= {redirect_pc[31:2], 2'b00}.
  - IF/ID becomes a bubble: if_id_instr=NOP, if_id_valid=0. if_id_pc and if_id_pc4 hold.
  - flush_count += 1; fetch_count holds.
  - If redirect_pc[1:0] != 0, misalign_err <= 1. Only rst clears it.
- Redirect latency: the target instruction appears in IF/ID with valid=1 on the second edge after redirect is sampled, provided no stall occurs in between. This gives the 1-bubble branch penalty at this stage.
- Counters are 32-bit and wrap on overflow.
- No handshake with IMEM: the read is single-cycle combinational.
- redirect=1 on consecutive cycles: each cycle is accepted independently and the last target wins.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN
  - NOP_INSTR = 32'h0000_0013
  - RESET_PC default
  - a packed struct if_id_t {pc, pc4, instr, valid}. Decode and the hazard unit reuse the same struct.
- Natural sub-module: if_id_reg, the pipeline register with hold/flush/load controls. The PC and counter logic stays in if_stage.

Test Plan:
1. Reset then free-run with IMEM word k = 32'h0010_0093+k, no stall/redirect. Expected:
   - if_id_valid rises on the 1st edge after reset release.
   - if_id_pc sequence is 0, 4, 8, 12 with matching instrs.
   - fetch_count = 4 after 4 edges.
2. Assert stall for 3 cycles while if_id_pc=8. Expected:
   - pc stays 12, IF/ID stays {8, 12, instr2, 1}, fetch_count frozen.
   - After release, the next IF/ID entry is pc=12.
3. Assert redirect with redirect_pc=32'h40 while pc=16. Expected:
   - Next edge: if_id_valid=0, if_id_instr=0x13, imem_addr=0x40, flush_count=1.
   - Following edge: if_id_pc=0x40, if_id_valid=1.
4. Assert redirect and stall together, redirect_pc=0x20. Expected: redirect wins; pc=0x20, bubble inserted, flush_count increments.
5. Redirect with redirect_pc=32'h22. Expected:
   - pc=0x20, misalign_err=1.
   - misalign_err stays 1 through later normal fetches and clears only on rst.
6. Load pc=32'hFFFF_FFFC via redirect, then one normal cycle. Expected:
   - pc wraps to 0, if_id_pc=32'hFFFF_FFFC, if_id_pc4=0.
   - Then assert rst during a stall: all outputs return to reset values on that edge.
